// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-flop synchroniser, debouncer and press/release pulses.
// Optional auto-repeat on masked keys is built when KEY_CONDITIONER_REPEAT_EN is defined.
module key_conditioner #(
   parameter int unsigned          N_KEYS          = 4,
   parameter int unsigned          DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned          REPEAT_DELAY    = 25000000,
   parameter int unsigned          REPEAT_PERIOD   = 5000000,
   parameter logic [N_KEYS-1:0]    REPEAT_MASK     = 4'b1000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [N_KEYS-1:0] i_key_n,
   output logic [N_KEYS-1:0] o_level,
   output logic [N_KEYS-1:0] o_press,
   output logic [N_KEYS-1:0] o_release
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_CONDITIONER_REPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0) ^ (|REPEAT_MASK);
`endif

   for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      logic [1:0]       r_sync;
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             w_s;
      logic             w_diff;
      logic             w_accept;
      logic             w_rise;
      logic             w_fall;
      logic             w_rpt;

      // Synchroniser holds the raw active-low value, so reset to 1 means released.
      assign w_s      = ~r_sync[1];
      assign w_diff   = w_s ^ r_level;
      assign w_accept = w_diff && (r_cnt == CNT_MAX);
      assign w_rise   = w_accept & ~r_level;
      assign w_fall   = w_accept & r_level;

      always_ff @(posedge i_clk or posedge i_reset) begin
         if (i_reset) begin
            r_sync    <= 2'b11;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_sync <= {r_sync[0], i_key_n[gi]};
            if (!w_diff || w_accept) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
               r_level <= ~r_level;
            end
            r_press   <= w_rise | w_rpt;
            r_release <= w_fall;
         end
      end

`ifdef KEY_CONDITIONER_REPEAT_EN
      if (REPEAT_MASK[gi]) begin : g_rpt
         logic [RPT_W-1:0] r_rcnt;
         logic             r_rptd;
         logic [RPT_W-1:0] w_target;

         // First repeat waits REPEAT_DELAY; later ones REPEAT_PERIOD. Counter restarts on each pulse.
         assign w_target = r_rptd ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
         assign w_rpt    = r_level & ~w_fall & (r_rcnt == w_target);

         always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
               r_rcnt <= '0;
               r_rptd <= 1'b0;
            end else if (!r_level || w_fall) begin
               r_rcnt <= '0;
               r_rptd <= 1'b0;
            end else begin
               if (r_press) begin
                  r_rcnt <= RPT_W'(1);
               end else begin
                  r_rcnt <= r_rcnt + 1'b1;
               end
               if (w_rpt) begin
                  r_rptd <= 1'b1;
               end
            end
         end
      end else begin : g_norpt
         assign w_rpt = 1'b0;
      end
`else
      assign w_rpt = 1'b0;
`endif

      assign o_level[gi]   = r_level;
      assign o_press[gi]   = r_press;
      assign o_release[gi] = r_release;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed test-plan scenarios plus random key traffic
// against a sliding-window reference model.
module tb_key_conditioner;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 5;
   localparam logic [N-1:0] MASK = 4'b1000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] key_n = '1;
   logic [N-1:0] level;
   logic [N-1:0] press;
   logic [N-1:0] rel;

   int checks = 0;
   int errors = 0;

   // Reference model state: pressed-vector sampled at each edge since reset.
   logic [N-1:0] hist[$];
   logic [N-1:0] m_level = '0;
   logic [N-1:0] m_press = '0;
   logic [N-1:0] m_rel   = '0;
   int           rcnt[N];
   bit           rptd[N];

   key_conditioner #(
      .N_KEYS         (N),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
      .REPEAT_MASK    (MASK)
   ) dut (
      .i_clk    (clk),
      .i_reset  (rst),
      .i_key_n  (key_n),
      .o_level  (level),
      .o_press  (press),
      .o_release(rel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      for (int k = 0; k < N; k++) begin
         rcnt[k] = 0;
         rptd[k] = 1'b0;
      end
   endtask

   // A key toggles once the last D synchronised samples all disagree with its level.
   task automatic model_edge(input logic [N-1:0] raw);
      logic [N-1:0] flip;
      flip    = '0;
      m_press = '0;
      m_rel   = '0;
      for (int k = 0; k < N; k++) begin
         bit all_diff;
         all_diff = 1'b1;
         for (int j = 2; j <= D + 1; j++) begin
            logic smp;
            smp = (hist.size() >= j) ? hist[hist.size() - j][k] : 1'b0;
            if (smp == m_level[k]) all_diff = 1'b0;
         end
         if (all_diff) begin
            flip[k] = 1'b1;
            if (m_level[k]) m_rel[k] = 1'b1;
            else m_press[k] = 1'b1;
         end
`ifdef KEY_CONDITIONER_REPEAT_EN
         if (MASK[k]) begin
            if (m_level[k] && !m_rel[k]) begin
               rcnt[k]++;
               if (rcnt[k] == (rptd[k] ? RP : RD)) begin
                  m_press[k] = 1'b1;
                  rptd[k]    = 1'b1;
                  rcnt[k]    = 0;
               end
            end else begin
               rcnt[k] = 0;
               rptd[k] = 1'b0;
            end
         end
`endif
      end
      m_level = m_level ^ flip;
      hist.push_back(raw);
      if (hist.size() > D + 1) void'(hist.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge(~key_n);
      #1;
      check("level", level, m_level);
      check("press", press, m_press);
      check("release", rel, m_rel);
   endtask

   initial begin
      int first;
      int cnt;
      int t3[8];
      int n3;
      int n0;
      int t0_first;
      logic [N-1:0] snap;

      model_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();

      // Clean press on key 0
      key_n = 4'b1110;
      first = -1;
      cnt   = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (press[0]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      check_int("press0_latency", first, 6);
      check_int("press0_count", cnt, 1);

      // Release key 0
      key_n = 4'b1111;
      first = -1;
      cnt   = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (rel[0]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      check_int("release0_latency", first, 6);
      check_int("release0_count", cnt, 1);

      // Bounce on key 1: 3 low, 1 high, 3 low, then high
      cnt = 0;
      key_n = 4'b1101;
      for (int i = 0; i < 3; i++) begin tick(); cnt += int'(press[1]); end
      key_n = 4'b1111;
      tick(); cnt += int'(press[1]);
      key_n = 4'b1101;
      for (int i = 0; i < 3; i++) begin tick(); cnt += int'(press[1]); end
      key_n = 4'b1111;
      for (int i = 0; i < 10; i++) begin tick(); cnt += int'(press[1]); end
      check_int("bounce_press1_count", cnt, 0);
      check("bounce_level", level, 4'b0000);

      // Simultaneous keys
      key_n = 4'b0101;
      snap  = '0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 6) snap = press;
      end
      check("simul_press_a", snap, 4'b1010);
      key_n = 4'b0000;
      snap  = '0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 6) snap = press;
      end
      check("simul_press_b", snap, 4'b0101);
      key_n = 4'b1111;
      for (int i = 0; i < 14; i++) tick();

      // Reset mid-debounce on key 2
      key_n = 4'b1011;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      #1;
      check("async_reset_outputs", level | press | rel, 4'b0000);
      for (int i = 0; i < 3; i++) tick();
      rst   = 1'b0;
      first = -1;
      cnt   = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (press[2]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      check_int("reset_press2_latency", first, 6);
      check_int("reset_press2_count", cnt, 1);
      key_n = 4'b1111;
      for (int i = 0; i < 12; i++) tick();

      // Hold keys 0 and 3 for 30 cycles
      key_n    = 4'b0110;
      n3       = 0;
      n0       = 0;
      t0_first = -1;
      for (int i = 0; i < 8; i++) t3[i] = -1;
      for (int i = 1; i <= 44; i++) begin
         if (i == 31) key_n = 4'b1111;
         tick();
         if (press[3]) begin
            if (n3 < 8) t3[n3] = i;
            n3++;
         end
         if (press[0]) begin
            n0++;
            if (t0_first < 0) t0_first = i;
         end
      end
      check_int("hold_key0_count", n0, 1);
      check_int("hold_key0_time", t0_first, 6);
      check_int("hold_key3_first", t3[0], 6);
`ifdef KEY_CONDITIONER_REPEAT_EN
      check_int("hold_key3_count", n3, 5);
      check_int("hold_key3_rpt1", t3[1], 16);
      check_int("hold_key3_rpt2", t3[2], 21);
      check_int("hold_key3_rpt3", t3[3], 26);
      check_int("hold_key3_rpt4", t3[4], 31);
`else
      check_int("hold_key3_count", n3, 1);
`endif

      // Random key traffic with occasional resets
      for (int it = 0; it < 300; it++) begin
         int hold;
         key_n = N'($urandom);
         hold  = int'($urandom_range(1, 7));
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
         end
         for (int h = 0; h < hold; h++) tick();
      end
      key_n = 4'b1111;
      for (int i = 0; i < 12; i++) tick();
      check("final_level", level, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
